reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 28 ++
 rtl/reg_file_ram_if.sv | 27 ++
 rtl/reg_file.sv | 114 +++++++++++
 tb/tb_reg_file.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared register map and STATUS bit positions for the APB register file.
// Holds no logic, so it adds no latency and has no backpressure behaviour.
package reg_file_pkg;

    typedef enum logic [3:0] {
        STATUS         = 4'd0,
        GO             = 4'd1,
        CENT_1         = 4'd2,
        CENT_2         = 4'd3,
        CENT_3         = 4'd4,
        CENT_4         = 4'd5,
        CENT_5         = 4'd6,
        CENT_6         = 4'd7,
        CENT_7         = 4'd8,
        CENT_8         = 4'd9,
        RAM_ADDR       = 4'd10,
        RAM_DATA       = 4'd11,
        FIRST_RAM_ADDR = 4'd12,
        LAST_RAM_ADDR  = 4'd13
    } reg_idx_t;

    localparam int REG_COUNT       = 14;
    // STATUS and GO are not plain storage; data registers start at CENT_1.
    localparam int FIRST_DATA_REG  = 2;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/reg_file_ram_if.sv
// Turns an accepted RAM_DATA write into a one-cycle active-low RAM write strobe.
// Latency: strobe is driven in the cycle after the request edge.
// Backpressure: none; one strobe per request, requests are never dropped.
module reg_file_ram_if (
    input  logic clk,
    input  logic rst,
    input  logic wr_req,
    output logic chip_select_ram_n,
    output logic out_en_ram_n,
    output logic w_r_ram_n
);

    logic wr_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_req;
        end
    end

    assign chip_select_ram_n = ~wr_pulse;
    assign w_r_ram_n         = wr_pulse;
    assign out_en_ram_n      = 1'b1;

endmodule

// File: rtl/reg_file.sv
// APB-accessible control/status register file shared with a compute core and a RAM port.
// Latency: writes commit on the access edge; reads are combinational; go/RAM strobes one cycle later.
// Backpressure: none, pready is tied high (zero wait states).
module reg_file
    import reg_file_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 91
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addrWidth-1:0] paddr,
    input  logic                 pwrite,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [dataWidth-1:0] pwdata,
    output logic [dataWidth-1:0] prdata,
    output logic                 pready,
    input  logic [addrWidth-1:0] reg_num,
    input  logic                 reg_write,
    input  logic [dataWidth-1:0] reg_write_data,
    output logic                 interupt,
    output logic                 go_core,
    output logic                 w_r_ram_n,
    output logic                 out_en_ram_n,
    output logic                 chip_select_ram_n,
    output logic [dataWidth-1:0] data2core,
    output logic [dataWidth-1:0] address2core
);

    logic                 busy;
    logic                 done;
    logic [dataWidth-1:0] regs [FIRST_DATA_REG:REG_COUNT-1];

    logic apb_wr;
    logic apb_status_wr;
    logic core_status_wr;
    logic go_accept;
    logic ram_wr_req;

    assign apb_wr         = psel & penable & pwrite;
    assign apb_status_wr  = apb_wr && (paddr == addrWidth'(STATUS));
    assign core_status_wr = reg_write && (reg_num == addrWidth'(STATUS));
    // A core update of STATUS on the same edge owns busy/done, so GO is not accepted then.
    assign go_accept      = apb_wr && (paddr == addrWidth'(GO)) && pwdata[0]
                            && !busy && !core_status_wr;
    assign ram_wr_req     = apb_wr && (paddr == addrWidth'(RAM_DATA)) && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            go_core <= 1'b0;
        end else begin
            go_core <= go_accept;
            if (core_status_wr) begin
                busy <= reg_write_data[STATUS_BUSY_BIT];
                done <= reg_write_data[STATUS_DONE_BIT];
            end else if (go_accept) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (apb_status_wr) begin
                done <= 1'b0;
            end
        end
    end

    // Core writes are always accepted and take priority; APB writes are locked out while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = FIRST_DATA_REG; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = FIRST_DATA_REG; i < REG_COUNT; i++) begin
                if (reg_write && (reg_num == addrWidth'(i))) begin
                    regs[i] <= reg_write_data;
                end else if (apb_wr && !busy && (paddr == addrWidth'(i))) begin
                    regs[i] <= pwdata;
                end
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            if (paddr == addrWidth'(STATUS)) begin
                prdata[STATUS_BUSY_BIT] = busy;
                prdata[STATUS_DONE_BIT] = done;
            end
            for (int i = FIRST_DATA_REG; i < REG_COUNT; i++) begin
                if (paddr == addrWidth'(i)) begin
                    prdata = regs[i];
                end
            end
        end
    end

    assign pready       = 1'b1;
    assign interupt     = done;
    assign address2core = regs[int'(RAM_ADDR)];
    assign data2core    = regs[int'(RAM_DATA)];

    reg_file_ram_if u_ram_if (
        .clk               (clk),
        .rst               (rst),
        .wr_req            (ram_wr_req),
        .chip_select_ram_n (chip_select_ram_n),
        .out_en_ram_n      (out_en_ram_n),
        .w_r_ram_n         (w_r_ram_n)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: APB/core/RAM sequences checked against a queued scoreboard.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int AW = 8;
    localparam int DW = 91;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic          pwrite = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic [AW-1:0] reg_num = '0;
    logic          reg_write = 1'b0;
    logic [DW-1:0] reg_write_data = '0;
    logic          interupt;
    logic          go_core;
    logic          w_r_ram_n;
    logic          out_en_ram_n;
    logic          chip_select_ram_n;
    logic [DW-1:0] data2core;
    logic [DW-1:0] address2core;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } ram_exp_t;

    logic [DW-1:0] rd_q[$];
    ram_exp_t      ram_q[$];

    always #5 clk = ~clk;

    reg_file #(.addrWidth(AW), .dataWidth(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .paddr             (paddr),
        .pwrite            (pwrite),
        .psel              (psel),
        .penable           (penable),
        .pwdata            (pwdata),
        .prdata            (prdata),
        .pready            (pready),
        .reg_num           (reg_num),
        .reg_write         (reg_write),
        .reg_write_data    (reg_write_data),
        .interupt          (interupt),
        .go_core           (go_core),
        .w_r_ram_n         (w_r_ram_n),
        .out_en_ram_n      (out_en_ram_n),
        .chip_select_ram_n (chip_select_ram_n),
        .data2core         (data2core),
        .address2core      (address2core)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rd_q.push_back(exp);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        check(tag, prdata, rd_q.pop_front());
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic core_write(input logic [AW-1:0] n, input logic [DW-1:0] d);
        @(posedge clk); #1;
        reg_write = 1'b1; reg_num = n; reg_write_data = d;
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic check_ram_idle(input string tag);
        check({tag, "_cs_n"}, chip_select_ram_n, 1);
        check({tag, "_oe_n"}, out_en_ram_n, 1);
        check({tag, "_wr"}, w_r_ram_n, 0);
    endtask

    // Programs RAM_ADDR then RAM_DATA and checks the strobe that follows the data commit.
    task automatic ram_write(input logic [DW-1:0] a, input logic [DW-1:0] d, input string tag);
        ram_exp_t e;
        apb_write(AW'(RAM_ADDR), a);
        ram_q.push_back('{addr: a, data: d});
        apb_write(AW'(RAM_DATA), d);
        e = ram_q.pop_front();
        check({tag, "_cs_n"}, chip_select_ram_n, 0);
        check({tag, "_wr"}, w_r_ram_n, 1);
        check({tag, "_oe_n"}, out_en_ram_n, 1);
        check({tag, "_addr"}, address2core, e.addr);
        check({tag, "_data"}, data2core, e.data);
        @(posedge clk); #1;
        check_ram_idle({tag, "_end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wide;
        wide = DW'({$urandom(), $urandom(), $urandom()});

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", pready, 1);
        check("rst_go", go_core, 0);
        check("rst_irq", interupt, 0);
        check("rst_prdata", prdata, 0);
        check_ram_idle("rst_ram");
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            apb_read(AW'(a), '0, "init_read");
        end
        check("pready", pready, 1);
        check_ram_idle("init_ram");

        ram_write(1, 6, "ram1");
        ram_write(2, 12, "ram2");
        apb_read(AW'(RAM_ADDR), 2, "rd_ram_addr");
        apb_read(AW'(RAM_DATA), 12, "rd_ram_data");

        apb_write(AW'(GO), 1);
        check("go_pulse", go_core, 1);
        @(posedge clk); #1;
        check("go_pulse_end", go_core, 0);
        apb_read(AW'(STATUS), 1, "status_busy");
        apb_read(AW'(GO), 0, "go_reads_0");
        apb_write(AW'(GO), 1);
        check("go_while_busy", go_core, 0);

        apb_write(AW'(RAM_ADDR), 1);
        apb_write(AW'(RAM_DATA), 7);
        check_ram_idle("busy_ram");
        apb_write(AW'(CENT_3), 33);
        apb_read(AW'(RAM_ADDR), 2, "busy_ram_addr");
        apb_read(AW'(RAM_DATA), 12, "busy_ram_data");
        apb_read(AW'(CENT_3), 0, "busy_cent3");

        core_write(AW'(STATUS), 2);
        check("irq_set", interupt, 1);
        apb_read(AW'(STATUS), 2, "status_done");
        apb_write(AW'(STATUS), 0);
        check("irq_clr", interupt, 0);
        apb_read(AW'(STATUS), 0, "status_clr");

        // APB and core both hit CENT_1 on the same edge.
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = AW'(CENT_1); pwdata = 5;
        @(posedge clk); #1;
        penable = 1'b1;
        reg_write = 1'b1; reg_num = AW'(CENT_1); reg_write_data = 9;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reg_write = 1'b0;
        apb_read(AW'(CENT_1), 9, "cent1_core_wins");

        apb_write(AW'(LAST_RAM_ADDR), wide);
        apb_read(AW'(LAST_RAM_ADDR), wide, "wide_rw");
        apb_write(AW'(CENT_8), 85);
        apb_read(AW'(CENT_8), 85, "cent8_rw");
        apb_write(8'd14, 99);
        apb_read(8'd14, 0, "addr14_ignored");

        // Reset during an active RAM strobe with a read in progress.
        apb_write(AW'(RAM_ADDR), 3);
        apb_write(AW'(RAM_DATA), 5);
        psel = 1'b1; pwrite = 1'b0; paddr = AW'(RAM_DATA);
        #1;
        check("pre_rst_prdata", prdata, 5);
        check("pre_rst_cs_n", chip_select_ram_n, 0);
        rst = 1'b1;
        #1;
        check_ram_idle("midrst_ram");
        check("midrst_prdata", prdata, 0);
        check("midrst_addr2core", address2core, 0);
        check("midrst_data2core", data2core, 0);
        check("midrst_pready", pready, 1);
        psel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        core_write(AW'(STATUS), 2);
        check("irq_before_rst", interupt, 1);
        rst = 1'b1;
        #1;
        check("rst_irq_clr", interupt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        apb_write(AW'(GO), 1);
        check("go_before_rst", go_core, 1);
        rst = 1'b1;
        #1;
        check("rst_go_clr", go_core, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        apb_read(AW'(STATUS), 0, "post_rst_status");
        apb_read(AW'(CENT_1), 0, "post_rst_cent1");
        apb_read(AW'(LAST_RAM_ADDR), 0, "post_rst_last");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
